// File: rtl/uart_pkg.sv
// Shared UART definitions for the FIFO drain stage: FSM state encoding,
// frame geometry and a small index-width helper.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps; clr forces it back to
// zero so every bit period starts fresh with no accumulated drift.
module baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clr || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART drain stage for the word FIFO: pops one word at a time and sends its
// bytes least-significant first as back-to-back 8N1 frames on tx.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  word_done
);
    localparam int                NUM_BYTES = DATA_WIDTH / UART_DATA_BITS;
    localparam int                BYTE_W    = idxWidth(NUM_BYTES);
    localparam int                BIT_W     = idxWidth(UART_DATA_BITS);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [BIT_W-1:0]      bitIdx_q, bitIdx_d;
    logic [BYTE_W-1:0]     byteIdx_q, byteIdx_d;
    logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic                  wordDone_q, wordDone_d;
    logic                  baudClr;
    logic                  baudTick;

    // The timer only runs inside a frame and restarts on every state change.
    assign baudClr = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_WAIT);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baudClr),
        .tick(baudTick)
    );

    // Pop is gated by rst so the FIFO never loses a word while we are held in reset.
    assign fifo_pop  = !rst && (state_q == ST_IDLE) && !fifo_empty;
    assign busy      = (state_q != ST_IDLE) || fifo_pop;
    assign word_done = wordDone_q;

    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shiftReg_q[bitIdx_q];
            default:  tx = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bitIdx_d   = bitIdx_q;
        byteIdx_d  = byteIdx_q;
        shiftReg_d = shiftReg_q;
        wordDone_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                shiftReg_d = fifo_data;
                byteIdx_d  = '0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (baudTick) begin
                    bitIdx_d = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baudTick) begin
                    if (bitIdx_q == LAST_BIT) begin
                        bitIdx_d = '0;
                        state_d  = ST_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (baudTick) begin
                    if (byteIdx_q == LAST_BYTE) begin
                        state_d    = ST_IDLE;
                        wordDone_d = 1'b1;
                    end else begin
                        shiftReg_d = shiftReg_q >> UART_DATA_BITS;
                        byteIdx_d  = byteIdx_q + BYTE_W'(1);
                        state_d    = ST_START;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bitIdx_q   <= '0;
            byteIdx_q  <= '0;
            shiftReg_q <= '0;
            wordDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitIdx_q   <= bitIdx_d;
            byteIdx_q  <= byteIdx_d;
            shiftReg_q <= shiftReg_d;
            wordDone_q <= wordDone_d;
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain stage that sits directly downstream of the 32-bit word FIFO. Whenever the FIFO is non-empty, it pops one word, splits it into bytes, and shifts each byte out as an 8N1 UART frame on `tx`. It runs back-to-back until the FIFO reports empty. It is the only consumer of the FIFO's `pop`/`data_out` pair.

## Interface
Parameters:
- `DATA_WIDTH`, 32: FIFO word width. Must be a multiple of 8.
- `CLKS_PER_BIT`, 868: clk cycles per UART bit. Minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO read data. Valid from the clk edge that samples `fifo_pop` onward.
- `fifo_pop`  out  1  one-cycle pop request to the FIFO.
- `tx`  out  1  UART serial line. Idles high.
- `busy`  out  1  high from the pop cycle through the last stop bit of a word.
- `word_done`  out  1  one-cycle pulse in the cycle after a word's final stop bit completes.

## Operation
- States: IDLE, WAIT, START, DATA, STOP.
- IDLE
  - `fifo_pop = !fifo_empty` (combinational, only in IDLE).
  - If `!fifo_empty`, go to WAIT.
- WAIT (exactly 1 cycle)
  - At the edge leaving WAIT, load `fifo_data` into the word shift register.
  - Clear byte index = 0, go to START.
- START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
- DATA
  - `tx` = current byte bit[bit index], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP
  - `tx=1` for CLKS_PER_BIT cycles.
  - If byte index < DATA_WIDTH/8−1: shift the word right 8, increment byte index, go to START.
  - Else: go to IDLE and pulse `word_done`.
- Byte order: least-significant byte first. Word 0xAABBCCDD is sent as DD, CC, BB, AA.
- `fifo_pop` asserts only in IDLE with `!fifo_empty`. It is never asserted twice for one word.
- `fifo_empty` is ignored outside IDLE. A FIFO going empty mid-word does not abort the word.
- Baud counter
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT−1 and wraps to 0 on every bit boundary and every state change.
  - No drift is carried between bits.
- Reset values (asynchronous, immediate, including mid-frame):
  - `tx=1`, `fifo_pop=0`, `busy=0`, `word_done=0`.
  - State IDLE; counters and shift register 0.
  - A word interrupted by reset is lost and is not re-popped.

## Timing
- Pop to first start bit:
  - Pop asserted in cycle N (IDLE).
  - WAIT in cycle N+1.
  - `tx` falls at the start of cycle N+2.
- Word duration: START through last STOP = 10·CLKS_PER_BIT·(DATA_WIDTH/8) cycles (40·CLKS_PER_BIT at default).
- Back-to-back words:
  - `word_done` pulses in the IDLE cycle after the last stop bit. If `!fifo_empty`, `fifo_pop` asserts in that same cycle.
  - Inter-word gap on `tx` is exactly 2 extra idle-high cycles: IDLE and WAIT.
- Bytes within a word have no gap: each STOP is followed immediately by the next START.
- `busy` is high in WAIT/START/DATA/STOP and in the IDLE cycle in which `fifo_pop` is asserted.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants: IDLE=0, WAIT=1, START=2, DATA=3, STOP=4 (3-bit).
  - `UART_DATA_BITS=8`, `UART_FRAME_BITS=10`.
- One sub-module, `baud_counter`:
  - Parameter CLKS_PER_BIT.
  - Inputs `clk`, `rst`, `clr`; output `tick`, high on count CLKS_PER_BIT−1.
- The top level holds the FSM, bit/byte indices, and the word shift register.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset release with `fifo_empty=1`:
  - `tx=1`, `fifo_pop=0`, `busy=0` held for 100 cycles.
- Single word 0xA5C3_0F01, then empty:
  - Exactly one `fifo_pop`.
  - `tx` decodes to bytes 0x01, 0x0F, 0xC3, 0xA5.
  - `tx` falls 2 cycles after the pop.
  - `word_done` pulses 160 cycles after the first start bit.
- Two words queued (0x0000_00FF, 0x8000_0001):
  - Second pop occurs in the `word_done` cycle.
  - Gap between frames is exactly 2 high cycles.
  - Decoded bytes are FF 00 00 00 01 00 00 80.
- `fifo_empty` toggles high mid-word:
  - The word completes unchanged.
  - No pop until IDLE with `fifo_empty=0`.
- `rst` pulsed during DATA of byte 2:
  - `tx=1` and `busy=0` immediately.
  - After release with `fifo_empty=0`, a new pop occurs on the first clk edge, and a fresh START follows.
- Bit timing check:
  - Every `tx` level between transitions lasts a multiple of 4 cycles.
  - Each start bit is exactly 4 low cycles.
